mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_rr_picker.sv | 29 ++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU/memory types for the memory arbiter: RAM handshake states,
// arbiter FSM states and the source-id encoding used on grant_id.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int SRC_ID_W = 16;
    typedef logic [SRC_ID_W-1:0] src_id_t;

    // Data source of core c is 2*c, instruction source is 2*c+1.
    function automatic src_id_t make_src_id(input int unsigned core, input logic instr);
        return src_id_t'(core * 2 + (instr ? 1 : 0));
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: returns the first requesting core at or after rr,
// wrapping around, plus a valid flag when any core requests.
module rr_picker #(
    parameter int CPUS = 2,
    parameter int CW   = 1
) (
    input  logic [CPUS-1:0] req_i,
    input  logic [CW-1:0]   rr_i,
    output logic [CW-1:0]   idx_o,
    output logic            vld_o
);

    int c;

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        for (int i = 0; i < CPUS; i++) begin
            c = int'(rr_i) + i;
            if (c >= CPUS) c = c - CPUS;
            if (!vld_o && req_i[c]) begin
                vld_o = 1'b1;
                idx_o = CW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the instruction and data
// ports of CPUS cores; data beats instruction within a core, writes beat reads.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [CPUS-1:0]            cpu_iREN,
    input  logic [CPUS-1:0]            cpu_dREN,
    input  logic [CPUS-1:0]            cpu_dWEN,
    input  logic [CPUS*AW-1:0]         cpu_iaddr,
    input  logic [CPUS*AW-1:0]         cpu_daddr,
    input  logic [CPUS*DW-1:0]         cpu_dstore,
    output logic [CPUS-1:0]            cpu_iwait,
    output logic [CPUS-1:0]            cpu_dwait,
    output logic [CPUS*DW-1:0]         cpu_iload,
    output logic [CPUS*DW-1:0]         cpu_dload,
    output logic [AW-1:0]              ramaddr,
    output logic [DW-1:0]              ramstore,
    output logic                       ramREN,
    output logic                       ramWEN,
    input  logic [DW-1:0]              ramload,
    input  logic [1:0]                 ramstate,
    output logic                       busy,
    output logic [$clog2(2*CPUS)-1:0]  grant_id,
    output logic                       timeout_err
);

    localparam int CW   = idx_w(CPUS);
    localparam int GIDW = $clog2(2*CPUS);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q, state_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   gcore_q, gcore_d;
    logic            ginstr_q, ginstr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tout_q, tout_d;

    ramstate_e       rs;
    logic [CPUS-1:0] any_req;
    logic [CW-1:0]   pick_idx;
    logic            pick_vld;
    logic [CW-1:0]   rr_next;
    logic            g_active;

    logic [AW-1:0] iaddr_a  [CPUS];
    logic [AW-1:0] daddr_a  [CPUS];
    logic [DW-1:0] dstore_a [CPUS];

    for (genvar c = 0; c < CPUS; c++) begin : g_unpack
        assign iaddr_a[c]  = cpu_iaddr[c*AW +: AW];
        assign daddr_a[c]  = cpu_daddr[c*AW +: AW];
        assign dstore_a[c] = cpu_dstore[c*DW +: DW];
    end

    assign rs      = ramstate_e'(ramstate);
    assign any_req = cpu_iREN | cpu_dREN | cpu_dWEN;

    rr_picker #(
        .CPUS (CPUS),
        .CW   (CW)
    ) u_pick (
        .req_i (any_req),
        .rr_i  (rr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Pointer moves past the granted core on completion or timeout.
    always_comb begin
        if (CPUS == 1)                     rr_next = '0;
        else if (gcore_q == CW'(CPUS - 1)) rr_next = '0;
        else                               rr_next = gcore_q + CW'(1);
    end

    // The grant tracks the live request; a withdrawn request ends it at once.
    assign g_active = ginstr_q ? cpu_iREN[gcore_q]
                               : (cpu_dREN[gcore_q] | cpu_dWEN[gcore_q]);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gcore_d   = gcore_q;
        ginstr_d  = ginstr_q;
        cnt_d     = cnt_q;
        tout_d    = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        cpu_iwait = cpu_iREN;
        cpu_dwait = cpu_dREN | cpu_dWEN;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gcore_d  = pick_idx;
                    ginstr_d = ~(cpu_dREN[pick_idx] | cpu_dWEN[pick_idx]);
                    cnt_d    = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (!g_active) begin
                    state_d = IDLE;
                end else begin
                    if (ginstr_q) begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr_a[gcore_q];
                    end else begin
                        ramWEN   = cpu_dWEN[gcore_q];
                        ramREN   = cpu_dREN[gcore_q] & ~cpu_dWEN[gcore_q];
                        ramaddr  = daddr_a[gcore_q];
                        ramstore = dstore_a[gcore_q];
                    end
                    if (rs == RAM_ACCESS) begin
                        if (ginstr_q) cpu_iwait[gcore_q] = 1'b0;
                        else          cpu_dwait[gcore_q] = 1'b0;
                        rr_d    = rr_next;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                        if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                            tout_d  = 1'b1;
                            rr_d    = rr_next;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            gcore_q  <= '0;
            ginstr_q <= 1'b0;
            cnt_q    <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gcore_q  <= gcore_d;
            ginstr_q <= ginstr_d;
            cnt_q    <= cnt_d;
            tout_q   <= tout_d;
        end
    end

    assign busy        = (state_q == GRANT);
    assign grant_id    = busy ? GIDW'(make_src_id(32'(gcore_q), ginstr_q)) : '0;
    assign timeout_err = tout_q;
    assign cpu_iload   = {CPUS{ramload}};
    assign cpu_dload   = {CPUS{ramload}};

endmodule
